parallel_rx: RTL and testbench



---
 rtl/parallel_rx.sv | 131 +++++++++++++
 tb/tb_parallel_rx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_rx.sv
// Parallel command receiver: synchronises an external strobe, assembles BEATS words per
// command and hands each one off through a one-deep valid/ready buffer. Optional macro: PARALLEL_RX_TIMEOUT_EN.
module parallel_rx #(
  parameter int DAT_WIDTH      = 8,
  parameter int BEATS          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           par_clk,
  input  logic [DAT_WIDTH-1:0]           par_data,
  output logic [DAT_WIDTH*BEATS-1:0]     cmd,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [$clog2(BEATS+1)-1:0]     beat_cnt,
  output logic                           overrun,
  output logic                           timeout
);

  // state     | meaning
  // WAIT_HIGH | waiting for a synchronised par_clk rise
  // SAMPLE    | capture par_data into the assembly register
  // WAIT_LOW  | waiting for par_clk fall; frame completes here
  // DELIVER   | move the finished frame into the output buffer

  localparam int CMD_W = DAT_WIDTH * BEATS;
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {WAIT_HIGH, SAMPLE, WAIT_LOW, DELIVER} state_t;

  state_t              state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                sync_prev;
  logic                sync_cur;
  logic                rise, fall;
  logic [CMD_W-1:0]    asm_q;
  logic                timeout_fire;

  assign sync_cur = sync_q[SYNC_STAGES-1];
  assign rise     = sync_cur & ~sync_prev;
  assign fall     = ~sync_cur & sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], par_clk};
      sync_prev <= sync_cur;
    end
  end

`ifdef PARALLEL_RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr;
  logic             tmr_active;

  assign tmr_active   = (beat_cnt != '0) && ((state == WAIT_HIGH) || (state == WAIT_LOW));
  assign timeout_fire = tmr_active && (tmr == '0);

  // Down-counter reloaded on each capture; terminal count discards the partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state == SAMPLE) begin
      tmr <= TMR_LOAD;
    end else if (tmr_active && (tmr != '0)) begin
      tmr <= tmr - TMR_W'(1);
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_HIGH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HIGH: if (rise) state_nxt = SAMPLE;
      SAMPLE:    state_nxt = WAIT_LOW;
      WAIT_LOW:  if (fall) state_nxt = (beat_cnt == CNT_W'(BEATS)) ? DELIVER : WAIT_HIGH;
      DELIVER:   state_nxt = WAIT_HIGH;
      default:   state_nxt = WAIT_HIGH;
    endcase
    if (timeout_fire) state_nxt = WAIT_HIGH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= '0;
      beat_cnt  <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= timeout_fire;
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;
      case (state)
        SAMPLE: begin
          asm_q    <= {asm_q[CMD_W-DAT_WIDTH-1:0], par_data};
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        DELIVER: begin
          beat_cnt <= '0;
          // A full buffer only accepts the new frame if it is drained in this same cycle.
          if (!cmd_valid || cmd_ready) begin
            cmd       <= asm_q;
            cmd_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
        default: ;
      endcase
      if (timeout_fire) begin
        beat_cnt <= '0;
        asm_q    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_parallel_rx.sv
// Directed self-checking bench for parallel_rx (DAT_WIDTH=8, BEATS=8, TIMEOUT_CYCLES=100).
// Expectations for the idle test follow PARALLEL_RX_TIMEOUT_EN when it is defined.
module tb_parallel_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        par_clk = 1'b0;
  logic [7:0]  par_data = 8'h00;
  logic [63:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [3:0]  beat_cnt;
  logic        overrun;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int ovr_cnt = 0;
  int to_cnt = 0;
  logic [63:0] last_cmd = '0;

  parallel_rx #(.DAT_WIDTH(8), .BEATS(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .par_clk(par_clk), .par_data(par_data),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .beat_cnt(beat_cnt), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid) begin
      valid_cycles = valid_cycles + 1;
      last_cmd = cmd;
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (timeout) to_cnt = to_cnt + 1;
  end

  task automatic clear_mon();
    valid_cycles = 0;
    ovr_cnt = 0;
    to_cnt = 0;
  endtask

  // One full strobe; exp is the beat count expected once this word is captured.
  task automatic strobe(input logic [7:0] d, input int exp);
    int after;
    par_data = d;
    par_clk = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (beat_cnt !== 4'(exp)) begin
      errors++;
      $display("FAIL beat_cnt_high word=%h got=%0d want=%0d", d, beat_cnt, exp);
    end
    par_clk = 1'b0;
    repeat (8) @(negedge clk);
    after = (exp == 8) ? 0 : exp;
    checks++;
    if (beat_cnt !== 4'(after)) begin
      errors++;
      $display("FAIL beat_cnt_low word=%h got=%0d want=%0d", d, beat_cnt, after);
    end
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 8; i++) strobe(base + 8'(i), i + 1);
  endtask

  task automatic consume();
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    par_clk = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_valid, overrun, timeout, beat_cnt} !== 7'b0 || cmd !== 64'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b o=%b t=%b bc=%0d cmd=%h want all zero",
               cmd_valid, overrun, timeout, beat_cnt, cmd);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cmd_ready = 1'b1;
    clear_mon();
    send_frame(8'h01);
    cmd_ready = 1'b0;
    checks++;
    if (last_cmd !== 64'h0102030405060708) begin
      errors++;
      $display("FAIL basic_cmd got=%h want=%h", last_cmd, 64'h0102030405060708);
    end
    checks++;
    if (valid_cycles !== 1) begin
      errors++;
      $display("FAIL basic_valid_cycles got=%0d want=1", valid_cycles);
    end
    checks++;
    if (cmd_valid !== 1'b0 || ovr_cnt !== 0) begin
      errors++;
      $display("FAIL basic_after got v=%b ovr=%0d want v=0 ovr=0", cmd_valid, ovr_cnt);
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    send_frame(8'h11);
    send_frame(8'h21);
    checks++;
    if (cmd !== 64'h1112131415161718 || cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold got cmd=%h v=%b want cmd=%h v=1", cmd, cmd_valid, 64'h1112131415161718);
    end
    checks++;
    if (ovr_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_pulses got=%0d want=1", ovr_cnt);
    end
    consume();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_accept got v=%b want 0", cmd_valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h11);
    for (int i = 0; i < 7; i++) strobe(8'h21 + 8'(i), i + 1);
    par_data = 8'h28;
    par_clk = 1'b1;
    repeat (6) @(negedge clk);
    par_clk = 1'b0;
    // Fall reaches the FSM after 2 edges, DELIVER executes on the 4th edge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 64'h1112131415161718) begin
        errors++;
        $display("FAIL b2b_pre cyc=%0d got v=%b cmd=%h want v=1 cmd=%h", i, cmd_valid, cmd, 64'h1112131415161718);
      end
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 64'h2122232425262728) begin
      errors++;
      $display("FAIL b2b_load got v=%b cmd=%h want v=1 cmd=%h", cmd_valid, cmd, 64'h2122232425262728);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ovr_cnt !== 0 || cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_overrun got ovr=%0d v=%b want ovr=0 v=1", ovr_cnt, cmd_valid);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) strobe(8'h55 + 8'(i), i + 1);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (beat_cnt !== 4'd0 || cmd_valid !== 1'b0 || cmd !== 64'h0) begin
      errors++;
      $display("FAIL midreset_state got bc=%0d v=%b cmd=%h want 0 0 0", beat_cnt, cmd_valid, cmd);
    end
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    send_frame(8'hA0);
    checks++;
    if (cmd !== 64'hA0A1A2A3A4A5A6A7 || cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_cmd got=%h v=%b want=%h v=1", cmd, cmd_valid, 64'hA0A1A2A3A4A5A6A7);
    end
    checks++;
    if (ovr_cnt !== 0 || to_cnt !== 0) begin
      errors++;
      $display("FAIL midreset_pulses got ovr=%0d to=%0d want 0 0", ovr_cnt, to_cnt);
    end
    consume();
  endtask

  task automatic test_glitch();
    strobe(8'hC0, 1);
    strobe(8'hC1, 2);
    // High glitch in WAIT_HIGH that never spans a clk edge.
    #1 par_clk = 1'b1;
    #2 par_clk = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (beat_cnt !== 4'd2) begin
      errors++;
      $display("FAIL glitch_high got bc=%0d want 2", beat_cnt);
    end
    // Beat with a short low glitch while the strobe is high.
    par_data = 8'hC2;
    par_clk = 1'b1;
    repeat (3) @(negedge clk);
    #1 par_clk = 1'b0;
    #2 par_clk = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (beat_cnt !== 4'd3) begin
      errors++;
      $display("FAIL glitch_low got bc=%0d want 3", beat_cnt);
    end
    par_clk = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 3; i < 8; i++) strobe(8'hC0 + 8'(i), i + 1);
    checks++;
    if (cmd !== 64'hC0C1C2C3C4C5C6C7 || cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL glitch_cmd got=%h v=%b want=%h v=1", cmd, cmd_valid, 64'hC0C1C2C3C4C5C6C7);
    end
    consume();
  endtask

  task automatic test_timeout();
    clear_mon();
    for (int i = 0; i < 5; i++) strobe(8'h77 + 8'(i), i + 1);
    repeat (80) @(negedge clk);
    checks++;
    if (to_cnt !== 0 || beat_cnt !== 4'd5) begin
      errors++;
      $display("FAIL timeout_early got to=%0d bc=%0d want 0 5", to_cnt, beat_cnt);
    end
    repeat (70) @(negedge clk);
`ifdef PARALLEL_RX_TIMEOUT_EN
    checks++;
    if (to_cnt !== 1 || beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL timeout_fire got to=%0d bc=%0d want 1 0", to_cnt, beat_cnt);
    end
`else
    checks++;
    if (to_cnt !== 0 || beat_cnt !== 4'd5) begin
      errors++;
      $display("FAIL timeout_off got to=%0d bc=%0d want 0 5", to_cnt, beat_cnt);
    end
    do_reset();
`endif
    send_frame(8'h31);
    checks++;
    if (cmd !== 64'h3132333435363738 || cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next got=%h v=%b want=%h v=1", cmd, cmd_valid, 64'h3132333435363738);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_glitch();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
